// File: rtl/mini_fir_coeff_ld.sv
// ---------------------------------------------------------------------------
// mini_fir_coeff_ld
//
// Coefficient loader that sits directly upstream of the mini FIR datapath.
// Tap words arrive over a valid/ready stream and are written into a shadow
// bank. On a commit strobe, the whole shadow bank is copied to the active
// coefficient outputs in one edge. The datapath therefore never sees a
// partially updated tap set.
//
// Build option:
//   MINI_FIR_COEFF_SYM_EN  symmetric load. NWORDS = (NTAPS+1)/2, and word j
//                          writes tap j and tap NTAPS-1-j in the same beat.
//                          When undefined, there is one word per tap.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   i_ld_start  in   1-cycle pulse: begin (or restart) a load
//   i_ld_valid  in   load word valid
//   i_ld_data   in   load word [CW-1:0], tap 0 first
//   o_ld_ready  out  loader accepts a word this cycle
//   i_commit    in   1-cycle pulse: shadow -> active (honoured only in PEND)
//   o_coeff     out  active taps, tap k at [k*CW +: CW]
//   o_busy      out  high while loading or waiting for a commit
//   o_done      out  1-cycle pulse in the cycle the new taps appear
//   o_err       out  1-cycle pulse after an unfinished load is restarted
//
// Handshake: a word is consumed on a rising edge where i_ld_valid and
// o_ld_ready are both high. The source may hold i_ld_valid with
// o_ld_ready low; that word is not consumed and must be held until ready.
// o_ld_ready depends combinationally on i_ld_start, because a start pulse
// always wins over a beat in the same cycle.
// ---------------------------------------------------------------------------
module mini_fir_coeff_ld #(
    parameter int NTAPS = 7,
    parameter int CW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_ld_start,
    input  logic                i_ld_valid,
    input  logic [CW-1:0]       i_ld_data,
    output logic                o_ld_ready,
    input  logic                i_commit,
    output logic [NTAPS*CW-1:0] o_coeff,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);

`ifdef MINI_FIR_COEFF_SYM_EN
    localparam int NWORDS = (NTAPS + 1) / 2;
    localparam bit SYM    = 1'b1;
`else
    localparam int NWORDS = NTAPS;
    localparam bit SYM    = 1'b0;
`endif

    localparam int            IW       = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NTAPS*CW-1:0]   shadow_q;
    logic [NTAPS*CW-1:0]   coeff_q;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  beat;
    logic                  commit_ok;

    assign o_ld_ready = (state_q == S_LOAD) & ~i_ld_start;

    // ---------------- next-state / control ----------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        beat      = 1'b0;
        commit_ok = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A commit here is ignored: there is no complete shadow load.
                if (i_ld_start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                if (i_ld_start) begin
                    idx_d = '0;
                    err_d = 1'b1;
                end else if (i_ld_valid) begin
                    beat = 1'b1;
                    // idx parks on the last word instead of wrapping. The
                    // next start reloads it anyway.
                    if (idx_q == LAST_IDX) begin
                        state_d = S_PEND;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_PEND: begin
                // A start beats a simultaneous commit: the load restarts.
                if (i_ld_start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    err_d   = 1'b1;
                end else if (i_commit) begin
                    state_d   = S_IDLE;
                    commit_ok = 1'b1;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // ---------------- shadow and active banks ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            coeff_q  <= '0;
        end else begin
            if (beat) begin
                for (int k = 0; k < NTAPS; k++) begin
                    // In symmetric mode, a word also fills the mirror tap.
                    // The centre tap matches both terms and is written once.
                    if ((k == int'(idx_q)) ||
                        (SYM && (k == NTAPS - 1 - int'(idx_q)))) begin
                        shadow_q[k*CW +: CW] <= i_ld_data;
                    end
                end
            end
            if (commit_ok) begin
                coeff_q <= shadow_q;
            end
        end
    end

    assign o_coeff = coeff_q;
    assign o_busy  = (state_q != S_IDLE);
    assign o_done  = done_q;
    assign o_err   = err_q;

endmodule
